// File: rtl/spi_engine_offload_pkg.sv
// Shared definitions for the multi-slot SPI Engine offload sequencer.
//   - state_e : sequencer FSM encoding (idle, replaying commands, waiting for closing SYNC)
//   - CMD_W   : SPI Engine command word width
//   - slot_w(): width of a slot index, never narrower than one bit
package spi_engine_offload_pkg;

  localparam int unsigned CMD_W = 16;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StWaitSync = 2'd2
  } state_e;

  function automatic int unsigned slot_w(input int unsigned num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

endpackage

// File: rtl/spi_engine_offload_slot_mem.sv
// One program slot: command memory and SDO memory, each with its own write counter.
// Writes append at the current count and are dropped once the memory is full. Reads are
// combinational, so a read of the address being written in the same cycle returns old data.
// Ports:
//   clk_i                     clock
//   clear_i                   zero both write counts (array contents are kept)
//   cmd_wr_en_i/cmd_wr_data_i append one command word
//   sdo_wr_en_i/sdo_wr_data_i append one SDO word
//   cmd_rd_addr_i/cmd_rd_data_o, sdo_rd_addr_i/sdo_rd_data_o  combinational read ports
//   cmd_count_o               number of stored command words
module spi_engine_offload_slot_mem
  import spi_engine_offload_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned CMD_MEM_ADDR_WIDTH = 4,
  parameter int unsigned SDO_MEM_ADDR_WIDTH = 4
) (
  input  logic                          clk_i,
  input  logic                          clear_i,
  input  logic                          cmd_wr_en_i,
  input  logic [CMD_W-1:0]              cmd_wr_data_i,
  input  logic                          sdo_wr_en_i,
  input  logic [DATA_WIDTH-1:0]         sdo_wr_data_i,
  input  logic [CMD_MEM_ADDR_WIDTH-1:0] cmd_rd_addr_i,
  output logic [CMD_W-1:0]              cmd_rd_data_o,
  input  logic [SDO_MEM_ADDR_WIDTH-1:0] sdo_rd_addr_i,
  output logic [DATA_WIDTH-1:0]         sdo_rd_data_o,
  output logic [CMD_MEM_ADDR_WIDTH:0]   cmd_count_o
);

  localparam int unsigned CmdDepth = 2 ** CMD_MEM_ADDR_WIDTH;
  localparam int unsigned SdoDepth = 2 ** SDO_MEM_ADDR_WIDTH;

  logic [CMD_W-1:0]      cmd_mem_q [CmdDepth];
  logic [DATA_WIDTH-1:0] sdo_mem_q [SdoDepth];

  logic [CMD_MEM_ADDR_WIDTH:0] cmd_count_q, cmd_count_d;
  logic [SDO_MEM_ADDR_WIDTH:0] sdo_count_q, sdo_count_d;
  logic                        cmd_full, sdo_full;
  logic                        cmd_we, sdo_we;

  // Count reaches the depth exactly when its extra MSB sets.
  assign cmd_full = cmd_count_q[CMD_MEM_ADDR_WIDTH];
  assign sdo_full = sdo_count_q[SDO_MEM_ADDR_WIDTH];
  assign cmd_we   = cmd_wr_en_i && !cmd_full;
  assign sdo_we   = sdo_wr_en_i && !sdo_full;

  always_comb begin
    cmd_count_d = cmd_count_q;
    sdo_count_d = sdo_count_q;
    if (clear_i) begin
      cmd_count_d = '0;
      sdo_count_d = '0;
    end else begin
      if (cmd_we) cmd_count_d = cmd_count_q + (CMD_MEM_ADDR_WIDTH + 1)'(1);
      if (sdo_we) sdo_count_d = sdo_count_q + (SDO_MEM_ADDR_WIDTH + 1)'(1);
    end
  end

  // Counts describe the stored programs, so like the arrays they survive spi_resetn;
  // clear_i is their only clear.
  always_ff @(posedge clk_i) begin
    cmd_count_q <= cmd_count_d;
    sdo_count_q <= sdo_count_d;
  end

  always_ff @(posedge clk_i) begin
    if (cmd_we) cmd_mem_q[cmd_count_q[CMD_MEM_ADDR_WIDTH-1:0]] <= cmd_wr_data_i;
    if (sdo_we) sdo_mem_q[sdo_count_q[SDO_MEM_ADDR_WIDTH-1:0]] <= sdo_wr_data_i;
  end

  assign cmd_rd_data_o = cmd_mem_q[cmd_rd_addr_i];
  assign sdo_rd_data_o = sdo_mem_q[sdo_rd_addr_i];
  assign cmd_count_o   = cmd_count_q;

endmodule

// File: rtl/spi_engine_offload_seq.sv
// Multi-slot SPI Engine offload sequencer. Stores NUM_SLOTS command/SDO programs and replays
// the lowest-index triggered, non-empty slot for 1 + ctrl_repeat passes, each pass ending on
// the program's closing SYNC. Single clock domain (spi_clk).
// Optional feature: define SPI_ENGINE_OFFLOAD_TRIG_QUEUE_EN to remember triggers that arrive
// while busy in a pending register and service them once idle.
// Ports:
//   spi_clk, spi_resetn                       clock, async active-low reset
//   ctrl_cmd_wr_*, ctrl_sdo_wr_*              per-slot program writes
//   ctrl_mem_reset                            clear all slot write counts (idle only)
//   ctrl_enable / ctrl_enabled                enable request / status
//   ctrl_repeat                               extra passes per trigger
//   trigger                                   per-slot level trigger
//   cmd_*, sdo_data_*                         offload command / SDO streams
//   sdi_data_* -> offload_sdi_*               SDI pass-through
//   sync_*                                    SYNC stream, always accepted
//   active_slot, done                         slot being replayed, end-of-run pulse
module spi_engine_offload_seq
  import spi_engine_offload_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH         = 8,
  parameter  int unsigned CMD_MEM_ADDR_WIDTH = 4,
  parameter  int unsigned SDO_MEM_ADDR_WIDTH = 4,
  parameter  int unsigned NUM_SLOTS          = 2,
  localparam int unsigned SLOT_W             = slot_w(NUM_SLOTS)
) (
  input  logic                  spi_clk,
  input  logic                  spi_resetn,
  input  logic                  ctrl_cmd_wr_en,
  input  logic [SLOT_W-1:0]     ctrl_cmd_wr_slot,
  input  logic [CMD_W-1:0]      ctrl_cmd_wr_data,
  input  logic                  ctrl_sdo_wr_en,
  input  logic [SLOT_W-1:0]     ctrl_sdo_wr_slot,
  input  logic [DATA_WIDTH-1:0] ctrl_sdo_wr_data,
  input  logic                  ctrl_mem_reset,
  input  logic                  ctrl_enable,
  output logic                  ctrl_enabled,
  input  logic [7:0]            ctrl_repeat,
  input  logic [NUM_SLOTS-1:0]  trigger,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [CMD_W-1:0]      cmd,
  output logic                  sdo_data_valid,
  input  logic                  sdo_data_ready,
  output logic [DATA_WIDTH-1:0] sdo_data,
  input  logic                  sdi_data_valid,
  output logic                  sdi_data_ready,
  input  logic [DATA_WIDTH-1:0] sdi_data,
  input  logic                  sync_valid,
  output logic                  sync_ready,
  input  logic [7:0]            sync_data,
  output logic                  offload_sdi_valid,
  input  logic                  offload_sdi_ready,
  output logic [DATA_WIDTH-1:0] offload_sdi_data,
  output logic [SLOT_W-1:0]     active_slot,
  output logic                  done
);

  state_e                        state_q, state_d;
  logic [SLOT_W-1:0]             active_slot_q, active_slot_d;
  logic [7:0]                    repeat_left_q, repeat_left_d;
  logic [CMD_MEM_ADDR_WIDTH-1:0] cmd_rd_addr_q, cmd_rd_addr_d;
  logic [SDO_MEM_ADDR_WIDTH-1:0] sdo_rd_addr_q, sdo_rd_addr_d;
  logic                          done_q, done_d;

  logic [CMD_W-1:0]              slot_cmd       [NUM_SLOTS];
  logic [DATA_WIDTH-1:0]         slot_sdo       [NUM_SLOTS];
  logic [CMD_MEM_ADDR_WIDTH:0]   slot_cmd_count [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]          slot_nonempty;
  logic [CMD_MEM_ADDR_WIDTH:0]   cur_cmd_count;
  logic                          mem_clear;
  logic                          last_cmd;

  logic [NUM_SLOTS-1:0]          svc_src, svc_req;
  logic                          grant_valid;
  logic [SLOT_W-1:0]             grant_slot;

  logic                          unused_sync_data;

  // ---------------------------------------------------------------------------------------
  // Program storage
  // ---------------------------------------------------------------------------------------
  assign mem_clear = ctrl_mem_reset && (state_q == StIdle);

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    logic slot_locked;
    // The slot being replayed must not change under the reader.
    assign slot_locked = (state_q != StIdle) && (active_slot_q == SLOT_W'(i));

    spi_engine_offload_slot_mem #(
      .DATA_WIDTH         (DATA_WIDTH),
      .CMD_MEM_ADDR_WIDTH (CMD_MEM_ADDR_WIDTH),
      .SDO_MEM_ADDR_WIDTH (SDO_MEM_ADDR_WIDTH)
    ) u_mem (
      .clk_i         (spi_clk),
      .clear_i       (mem_clear),
      .cmd_wr_en_i   (ctrl_cmd_wr_en && (ctrl_cmd_wr_slot == SLOT_W'(i)) && !slot_locked),
      .cmd_wr_data_i (ctrl_cmd_wr_data),
      .sdo_wr_en_i   (ctrl_sdo_wr_en && (ctrl_sdo_wr_slot == SLOT_W'(i)) && !slot_locked),
      .sdo_wr_data_i (ctrl_sdo_wr_data),
      .cmd_rd_addr_i (cmd_rd_addr_q),
      .cmd_rd_data_o (slot_cmd[i]),
      .sdo_rd_addr_i (sdo_rd_addr_q),
      .sdo_rd_data_o (slot_sdo[i]),
      .cmd_count_o   (slot_cmd_count[i])
    );

    assign slot_nonempty[i] = |slot_cmd_count[i];
  end

  always_comb begin
    cmd           = '0;
    sdo_data      = '0;
    cur_cmd_count = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (active_slot_q == SLOT_W'(i)) begin
        cmd           = slot_cmd[i];
        sdo_data      = slot_sdo[i];
        cur_cmd_count = slot_cmd_count[i];
      end
    end
  end

  assign last_cmd = (({1'b0, cmd_rd_addr_q} + (CMD_MEM_ADDR_WIDTH + 1)'(1)) == cur_cmd_count);

  // ---------------------------------------------------------------------------------------
  // Trigger arbitration
  // ---------------------------------------------------------------------------------------
`ifdef SPI_ENGINE_OFFLOAD_TRIG_QUEUE_EN
  logic [NUM_SLOTS-1:0] pending_q, pending_d;

  assign svc_src = pending_q | trigger;

  always_comb begin
    pending_d = pending_q;
    if (!ctrl_enable) begin
      pending_d = '0;
    end else if (state_q != StIdle) begin
      pending_d = pending_q | trigger;
    end else if (grant_valid) begin
      pending_d = pending_q & ~(NUM_SLOTS'(1) << grant_slot);
    end
  end

  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  assign svc_src = trigger;
`endif

  assign svc_req = svc_src & slot_nonempty;

  // Lowest requesting index wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_slot  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!grant_valid && svc_req[i]) begin
        grant_valid = 1'b1;
        grant_slot  = SLOT_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------------------
  assign cmd_valid      = (state_q == StRun);
  assign sdo_data_valid = (state_q != StIdle);

  always_comb begin
    state_d       = state_q;
    active_slot_d = active_slot_q;
    repeat_left_d = repeat_left_q;
    cmd_rd_addr_d = cmd_rd_addr_q;
    sdo_rd_addr_d = sdo_rd_addr_q;
    done_d        = 1'b0;

    // SDO address wraps naturally at the memory depth.
    if (sdo_data_valid && sdo_data_ready) begin
      sdo_rd_addr_d = sdo_rd_addr_q + SDO_MEM_ADDR_WIDTH'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (ctrl_enable && grant_valid) begin
          state_d       = StRun;
          active_slot_d = grant_slot;
          repeat_left_d = ctrl_repeat;
          cmd_rd_addr_d = '0;
          sdo_rd_addr_d = '0;
        end
      end
      StRun: begin
        if (cmd_ready) begin
          cmd_rd_addr_d = cmd_rd_addr_q + CMD_MEM_ADDR_WIDTH'(1);
          if (last_cmd) state_d = StWaitSync;
        end
      end
      StWaitSync: begin
        if (sync_valid) begin
          // Dropping ctrl_enable abandons the remaining passes but not the current one.
          if ((repeat_left_q != 8'd0) && ctrl_enable) begin
            state_d       = StRun;
            repeat_left_d = repeat_left_q - 8'd1;
            cmd_rd_addr_d = '0;
            sdo_rd_addr_d = '0;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      state_q       <= StIdle;
      active_slot_q <= '0;
      repeat_left_q <= '0;
      cmd_rd_addr_q <= '0;
      sdo_rd_addr_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_slot_q <= active_slot_d;
      repeat_left_q <= repeat_left_d;
      cmd_rd_addr_q <= cmd_rd_addr_d;
      sdo_rd_addr_q <= sdo_rd_addr_d;
      done_q        <= done_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Outputs and pass-through
  // ---------------------------------------------------------------------------------------
  assign ctrl_enabled      = ctrl_enable || (state_q != StIdle);
  assign active_slot       = active_slot_q;
  assign done              = done_q;
  assign sync_ready        = 1'b1;
  assign offload_sdi_valid = sdi_data_valid;
  assign offload_sdi_data  = sdi_data;
  assign sdi_data_ready    = offload_sdi_ready;

  // SYNC payload carries nothing the sequencer needs.
  assign unused_sync_data = ^sync_data;

endmodule

// File: tb/tb_spi_engine_offload_seq.sv
// Directed, scoreboard-checked bench for spi_engine_offload_seq (default parameters).
module tb_spi_engine_offload_seq;
  import spi_engine_offload_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned NS = 2;
  localparam int unsigned SW = 1;

  logic          spi_clk = 1'b0;
  logic          spi_resetn;
  logic          ctrl_cmd_wr_en;
  logic [SW-1:0] ctrl_cmd_wr_slot;
  logic [15:0]   ctrl_cmd_wr_data;
  logic          ctrl_sdo_wr_en;
  logic [SW-1:0] ctrl_sdo_wr_slot;
  logic [DW-1:0] ctrl_sdo_wr_data;
  logic          ctrl_mem_reset;
  logic          ctrl_enable;
  logic          ctrl_enabled;
  logic [7:0]    ctrl_repeat;
  logic [NS-1:0] trigger;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [15:0]   cmd;
  logic          sdo_data_valid;
  logic          sdo_data_ready;
  logic [DW-1:0] sdo_data;
  logic          sdi_data_valid;
  logic          sdi_data_ready;
  logic [DW-1:0] sdi_data;
  logic          sync_valid;
  logic          sync_ready;
  logic [7:0]    sync_data;
  logic          offload_sdi_valid;
  logic          offload_sdi_ready;
  logic [DW-1:0] offload_sdi_data;
  logic [SW-1:0] active_slot;
  logic          done;

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;
  int d0;
  logic [15:0]   cmd_q [$];
  logic [DW-1:0] sdo_q [$];

  spi_engine_offload_seq #(
    .DATA_WIDTH         (8),
    .CMD_MEM_ADDR_WIDTH (4),
    .SDO_MEM_ADDR_WIDTH (4),
    .NUM_SLOTS          (2)
  ) dut (
    .spi_clk           (spi_clk),
    .spi_resetn        (spi_resetn),
    .ctrl_cmd_wr_en    (ctrl_cmd_wr_en),
    .ctrl_cmd_wr_slot  (ctrl_cmd_wr_slot),
    .ctrl_cmd_wr_data  (ctrl_cmd_wr_data),
    .ctrl_sdo_wr_en    (ctrl_sdo_wr_en),
    .ctrl_sdo_wr_slot  (ctrl_sdo_wr_slot),
    .ctrl_sdo_wr_data  (ctrl_sdo_wr_data),
    .ctrl_mem_reset    (ctrl_mem_reset),
    .ctrl_enable       (ctrl_enable),
    .ctrl_enabled      (ctrl_enabled),
    .ctrl_repeat       (ctrl_repeat),
    .trigger           (trigger),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd               (cmd),
    .sdo_data_valid    (sdo_data_valid),
    .sdo_data_ready    (sdo_data_ready),
    .sdo_data          (sdo_data),
    .sdi_data_valid    (sdi_data_valid),
    .sdi_data_ready    (sdi_data_ready),
    .sdi_data          (sdi_data),
    .sync_valid        (sync_valid),
    .sync_ready        (sync_ready),
    .sync_data         (sync_data),
    .offload_sdi_valid (offload_sdi_valid),
    .offload_sdi_ready (offload_sdi_ready),
    .offload_sdi_data  (offload_sdi_data),
    .active_slot       (active_slot),
    .done              (done)
  );

  always #5 spi_clk = ~spi_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor handshakes at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [31:0] exp;
    sdo_data_ready = (sdo_q.size() != 0);
    @(negedge spi_clk);
    if (done === 1'b1) done_cnt++;
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      if (cmd_q.size() != 0) exp = {16'h0, cmd_q.pop_front()};
      else exp = 32'hFFFF_FFFF;
      check("cmd_word", {16'h0, cmd}, exp);
    end
    if (sdo_data_valid === 1'b1 && sdo_data_ready === 1'b1) begin
      if (sdo_q.size() != 0) exp = {24'h0, sdo_q.pop_front()};
      else exp = 32'hFFFF_FFFF;
      check("sdo_word", {24'h0, sdo_data}, exp);
    end
    @(posedge spi_clk);
    #1;
  endtask

  task automatic wr_cmd(input logic [SW-1:0] s, input logic [15:0] d);
    ctrl_cmd_wr_en = 1'b1; ctrl_cmd_wr_slot = s; ctrl_cmd_wr_data = d;
    tick();
    ctrl_cmd_wr_en = 1'b0;
  endtask

  task automatic wr_sdo(input logic [SW-1:0] s, input logic [DW-1:0] d);
    ctrl_sdo_wr_en = 1'b1; ctrl_sdo_wr_slot = s; ctrl_sdo_wr_data = d;
    tick();
    ctrl_sdo_wr_en = 1'b0;
  endtask

  task automatic push_prog0();
    cmd_q.push_back(16'h1001); cmd_q.push_back(16'h1002); cmd_q.push_back(16'h3000);
  endtask

  task automatic push_prog1_full();
    for (int i = 0; i < 16; i++) cmd_q.push_back(16'h4000 + 16'(i));
  endtask

  // Bounded wait for the end of a pass's command stream.
  task automatic wait_cmd_low(input string tag);
    int n = 0;
    while (cmd_valid === 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check(tag, {31'h0, cmd_valid}, 32'h0);
  endtask

  task automatic sync_pulse();
    sync_valid = 1'b1;
    tick();
    sync_valid = 1'b0;
  endtask

  initial begin
    spi_resetn = 1'b0;
    ctrl_cmd_wr_en = 1'b0; ctrl_cmd_wr_slot = '0; ctrl_cmd_wr_data = '0;
    ctrl_sdo_wr_en = 1'b0; ctrl_sdo_wr_slot = '0; ctrl_sdo_wr_data = '0;
    ctrl_mem_reset = 1'b0; ctrl_enable = 1'b0; ctrl_repeat = '0; trigger = '0;
    cmd_ready = 1'b0; sdo_data_ready = 1'b0;
    sdi_data_valid = 1'b0; sdi_data = '0; offload_sdi_ready = 1'b0;
    sync_valid = 1'b0; sync_data = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check("rst_sdo_valid", {31'h0, sdo_data_valid}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_active_slot", {31'h0, active_slot}, 32'h0);
    check("rst_sync_ready", {31'h0, sync_ready}, 32'h1);
    check("rst_enabled", {31'h0, ctrl_enabled}, 32'h0);
    spi_resetn = 1'b1;
    tick();

    // SDI pass-through
    sdi_data_valid = 1'b1; sdi_data = 8'h3C; offload_sdi_ready = 1'b1;
    #1;
    check("sdi_valid", {31'h0, offload_sdi_valid}, 32'h1);
    check("sdi_data", {24'h0, offload_sdi_data}, 32'h3C);
    check("sdi_ready", {31'h0, sdi_data_ready}, 32'h1);
    sdi_data_valid = 1'b0; offload_sdi_ready = 1'b0;

    ctrl_mem_reset = 1'b1; tick(); ctrl_mem_reset = 1'b0;
    wr_cmd(0, 16'h1001); wr_cmd(0, 16'h1002); wr_cmd(0, 16'h3000);
    wr_sdo(0, 8'hA5); wr_sdo(0, 8'h5A);
    wr_cmd(1, 16'h2001); wr_cmd(1, 16'h3000);
    ctrl_enable = 1'b1; cmd_ready = 1'b1;
    #1;
    check("enabled_idle", {31'h0, ctrl_enabled}, 32'h1);

    // Single pass from slot 0
    push_prog0();
    sdo_q.push_back(8'hA5); sdo_q.push_back(8'h5A);
    d0 = done_cnt;
    trigger = 2'b01; tick(); trigger = 2'b00;
    check("t1_cmd_valid", {31'h0, cmd_valid}, 32'h1);
    check("t1_word0", {16'h0, cmd}, 32'h1001);
    check("t1_slot", {31'h0, active_slot}, 32'h0);
    wait_cmd_low("t1_run_end");
    check("t1_cmd_drained", cmd_q.size(), 32'h0);
    check("t1_sdo_drained", sdo_q.size(), 32'h0);
    check("t1_done_early", {31'h0, done}, 32'h0);
    sync_pulse();
    check("t1_done_pulse", {31'h0, done}, 32'h1);
    tick();
    check("t1_done_clear", {31'h0, done}, 32'h0);
    check("t1_done_count", done_cnt - d0, 32'h1);

    // Three passes with one bubble between them; ctrl_repeat is latched at the trigger
    ctrl_repeat = 8'd2;
    repeat (3) push_prog0();
    d0 = done_cnt;
    trigger = 2'b01; tick(); trigger = 2'b00;
    ctrl_repeat = 8'd0;
    for (int p = 0; p < 3; p++) begin
      check("t2_pass_start", {31'h0, cmd_valid}, 32'h1);
      check("t2_pass_word0", {16'h0, cmd}, 32'h1001);
      check("t2_no_done", {31'h0, done}, 32'h0);
      wait_cmd_low("t2_pass_end");
      sync_pulse();
    end
    check("t2_done_pulse", {31'h0, done}, 32'h1);
    tick();
    check("t2_done_count", done_cnt - d0, 32'h1);
    check("t2_cmd_drained", cmd_q.size(), 32'h0);

    // Simultaneous triggers: lowest index wins
    push_prog0();
    trigger = 2'b11; tick();
    check("t3_slot0_wins", {31'h0, active_slot}, 32'h0);
    trigger = 2'b10; tick(); trigger = 2'b00;
`ifdef SPI_ENGINE_OFFLOAD_TRIG_QUEUE_EN
    cmd_q.push_back(16'h2001); cmd_q.push_back(16'h3000);
`endif
    wait_cmd_low("t3_slot0_end");
    sync_pulse();
    check("t3_done", {31'h0, done}, 32'h1);
`ifdef SPI_ENGINE_OFFLOAD_TRIG_QUEUE_EN
    tick();
    check("t3_pending_runs", {31'h0, cmd_valid}, 32'h1);
    check("t3_pending_slot", {31'h0, active_slot}, 32'h1);
    wait_cmd_low("t3_slot1_end");
    sync_pulse();
    check("t3_slot1_done", {31'h0, done}, 32'h1);
`else
    repeat (4) tick();
    check("t3_slot1_dropped", {31'h0, cmd_valid}, 32'h0);
    check("t3_slot_held", {31'h0, active_slot}, 32'h0);
`endif
    tick();
    check("t3_cmd_drained", cmd_q.size(), 32'h0);

    // Clear all slots; empty slot trigger ignored; 17 writes into 16 entries
    ctrl_mem_reset = 1'b1; tick(); ctrl_mem_reset = 1'b0;
    trigger = 2'b01; tick(); trigger = 2'b00;
    check("t4_empty_ignored", {31'h0, cmd_valid}, 32'h0);
    for (int i = 0; i < 17; i++) wr_cmd(1, 16'h4000 + 16'(i));
    push_prog1_full();
    trigger = 2'b10; tick(); trigger = 2'b00;
    check("t4_slot1", {31'h0, active_slot}, 32'h1);
    // Memory reset and a write to the running slot must both be ignored.
    ctrl_mem_reset = 1'b1;
    wr_cmd(1, 16'h4EEE);
    ctrl_mem_reset = 1'b0;
    wait_cmd_low("t4_run_end");
    check("t4_exactly_16", cmd_q.size(), 32'h0);
    sync_pulse();
    tick();

    // ctrl_enable dropped during pass 1 of four
    ctrl_repeat = 8'd3;
    push_prog1_full();
    d0 = done_cnt;
    trigger = 2'b10; tick(); trigger = 2'b00;
    repeat (2) tick();
    ctrl_enable = 1'b0;
    #1;
    check("t5_enabled_busy", {31'h0, ctrl_enabled}, 32'h1);
    wait_cmd_low("t5_pass_end");
    check("t5_enabled_wait", {31'h0, ctrl_enabled}, 32'h1);
    sync_pulse();
    check("t5_done", {31'h0, done}, 32'h1);
    check("t5_enabled_fall", {31'h0, ctrl_enabled}, 32'h0);
    check("t5_no_more_cmd", {31'h0, cmd_valid}, 32'h0);
    repeat (3) tick();
    check("t5_stay_idle", {31'h0, cmd_valid}, 32'h0);
    check("t5_done_count", done_cnt - d0, 32'h1);
    check("t5_cmd_drained", cmd_q.size(), 32'h0);

    // Asynchronous reset mid-run, then replay from word 0
    ctrl_enable = 1'b1; ctrl_repeat = 8'd0;
    push_prog1_full();
    trigger = 2'b10; tick(); trigger = 2'b00;
    repeat (4) tick();
    spi_resetn = 1'b0;
    #2;
    check("t6_rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check("t6_rst_sdo_valid", {31'h0, sdo_data_valid}, 32'h0);
    check("t6_rst_slot", {31'h0, active_slot}, 32'h0);
    cmd_q.delete();
    tick();
    spi_resetn = 1'b1;
    tick();
    check("t6_idle_after_rst", {31'h0, cmd_valid}, 32'h0);
    push_prog1_full();
    trigger = 2'b10; tick(); trigger = 2'b00;
    check("t6_replay_word0", {16'h0, cmd}, 32'h4000);
    wait_cmd_low("t6_run_end");
    check("t6_cmd_drained", cmd_q.size(), 32'h0);
    sync_pulse();
    check("t6_done", {31'h0, done}, 32'h1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
